lsl8_seq: RTL and testbench

- Sequential 8-bit logical-shift-left unit. It is the left-direction companion of the combinational 8-bit logical-shift-right block in the shifter8 group.
- Accepts an operand and a 3-bit shift amount (0..7) under a start/busy/done handshake.
- Shifts by at most STEP_MAX bits per clock through a 4-way mux stage, so the result is produced in multiple cycles.
- Registered result and carry-out feed the counter_shifter datapath.

---
 rtl/lsl8_seq.sv | 113 +++++++++++
 tb/tb_lsl8_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsl8_seq.sv
// Sequential 8-bit logical shift left with a start/busy/done handshake.
// Shifts at most STEP_MAX bits per clock; d_out and c_out hold the result until the next start.
module lsl8_seq #(
    parameter int STEP_MAX = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] d_in,
    input  logic [2:0] shamt,
    output logic       busy,
    output logic       done,
    output logic [7:0] d_out,
    output logic       c_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] STEP_LIM = 3'(STEP_MAX);

    state_t     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       carry_q, carry_d;
    logic [2:0] count_q, count_d;

    logic [2:0] step;
    logic [7:0] shifted;
    logic       shift_carry;

    // The step never exceeds the remaining count, so count cannot underflow.
    always_comb begin
        step        = (count_q > STEP_LIM) ? STEP_LIM : count_q;
        shifted     = data_q;
        shift_carry = carry_q;
        case (step)
            3'd1: begin
                shifted     = {data_q[6:0], 1'b0};
                shift_carry = data_q[7];
            end
            3'd2: begin
                shifted     = {data_q[5:0], 2'b00};
                shift_carry = data_q[6];
            end
            3'd3: begin
                shifted     = {data_q[4:0], 3'b000};
                shift_carry = data_q[5];
            end
            default: begin
                shifted     = data_q;
                shift_carry = carry_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = d_in;
                    count_d = shamt;
                    carry_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = (count_q == 3'd0) ? DONE : SHIFT;
            end
            SHIFT: begin
                data_d  = shifted;
                carry_d = shift_carry;
                count_d = count_q - step;
                if (count_q == step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            carry_q <= 1'b0;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

    assign busy  = (state_q == LOAD) || (state_q == SHIFT);
    assign done  = (state_q == DONE);
    assign d_out = data_q;
    assign c_out = carry_q;

endmodule

// File: tb/tb_lsl8_seq.sv
// Self-checking bench for lsl8_seq: directed vector table, multi-cycle corner sequences
// and randomized operations compared against an arithmetic reference model.
module tb_lsl8_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] d_in;
    logic [2:0] shamt;
    logic       busy;
    logic       done;
    logic [7:0] d_out;
    logic       c_out;

    int n_checks = 0;
    int n_pass   = 0;

    lsl8_seq #(.STEP_MAX(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .d_in  (d_in),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .d_out (d_out),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic [7:0] exp_d;
        logic       exp_c;
        int         exp_lat;
        logic       inject;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the whole operand.
    function automatic logic [7:0] model_d(input logic [7:0] d, input logic [2:0] s);
        int wide;
        wide = int'(d) << s;
        return 8'(wide % 256);
    endfunction

    function automatic logic model_c(input logic [7:0] d, input logic [2:0] s);
        int wide;
        wide = int'(d) << s;
        return (s == 3'd0) ? 1'b0 : 1'((wide >> 8) & 1);
    endfunction

    // Done is first seen this many edges after the accepted-start edge.
    function automatic int model_lat(input logic [2:0] s);
        return 1 + ((int'(s) + 2) / 3);
    endfunction

    // Runs one operation from IDLE; optionally pokes an ignored start mid-operation.
    task automatic applyStimulus(input logic [7:0] d, input logic [2:0] s, input logic inject,
                                 output logic [7:0] r_d, output logic r_c, output int lat,
                                 output int pulses, output int busy_cycles, output logic [7:0] hold_d);
        lat = -1;
        pulses = 0;
        busy_cycles = 0;
        r_d = 8'h00;
        r_c = 1'b0;
        @(negedge clk);
        d_in  = d;
        shamt = s;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        d_in  = ~d;
        shamt = ~s;
        if (busy) busy_cycles++;
        for (int e = 1; e <= 30; e++) begin
            if (inject && e == 2) begin
                start = 1'b1;
                d_in  = 8'h01;
                shamt = 3'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = e;
                    r_d = d_out;
                    r_c = c_out;
                end
            end
            if (lat >= 0 && e >= lat + 4) break;
        end
        start = 1'b0;
        hold_d = d_out;
        if (lat < 0) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic runAndCheck(input string tag, input logic [7:0] d, input logic [2:0] s,
                               input logic inject, input logic [7:0] exp_d, input logic exp_c,
                               input int exp_lat);
        logic [7:0] r_d;
        logic [7:0] hold_d;
        logic       r_c;
        int         lat, pulses, busy_cycles;
        applyStimulus(d, s, inject, r_d, r_c, lat, pulses, busy_cycles, hold_d);
        checkOutput({tag, "_d_out"}, 32'(r_d), 32'(exp_d));
        checkOutput({tag, "_c_out"}, 32'(r_c), 32'(exp_c));
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_done_pulses"}, 32'(pulses), 32'd1);
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_lat));
        checkOutput({tag, "_hold"}, 32'(hold_d), 32'(exp_d));
    endtask

    initial begin
        logic [7:0] rd;
        logic [2:0] rs;
        int         seen_done;
        int         got;

        vecs = '{
            '{8'h5C, 3'd0, 8'h5C, 1'b0, 1, 1'b0},
            '{8'hB5, 3'd3, 8'hA8, 1'b1, 2, 1'b0},
            '{8'hFF, 3'd7, 8'h80, 1'b1, 4, 1'b0},
            '{8'h81, 3'd4, 8'h10, 1'b0, 3, 1'b0},
            '{8'h0F, 3'd5, 8'hE0, 1'b1, 3, 1'b1},
            '{8'hA5, 3'd1, 8'h4A, 1'b1, 2, 1'b0},
            '{8'h3C, 3'd6, 8'h00, 1'b1, 3, 1'b0},
            '{8'h96, 3'd2, 8'h58, 1'b0, 2, 1'b0}
        };

        reset = 1'b1;
        start = 1'b0;
        d_in  = 8'h00;
        shamt = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_d_out", 32'(d_out), 32'h00);
        checkOutput("reset_c_out", 32'(c_out), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].d, vecs[i].s, vecs[i].inject,
                        vecs[i].exp_d, vecs[i].exp_c, vecs[i].exp_lat);
        end

        // Reset in the middle of a long shift must abort without a done pulse.
        @(negedge clk);
        d_in  = 8'hFF;
        shamt = 3'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        seen_done = 0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_d_out", 32'(d_out), 32'h00);
        checkOutput("rst_mid_c_out", 32'(c_out), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        if (done) seen_done++;
        @(posedge clk);
        @(negedge clk);
        if (done) seen_done++;
        reset = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        checkOutput("rst_mid_no_done", 32'(seen_done), 32'd0);
        runAndCheck("after_rst", 8'h5A, 3'd3, 1'b0, model_d(8'h5A, 3'd3), model_c(8'h5A, 3'd3),
                    model_lat(3'd3));

        // Start held high continuously: each operation is accepted from IDLE after done.
        @(negedge clk);
        d_in  = 8'h01;
        shamt = 3'd0;
        start = 1'b1;
        for (int s = 0; s < 8; s++) begin
            got = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (done) begin
                    got = 1;
                    break;
                end
            end
            checkOutput($sformatf("b2b%0d_done", s), 32'(got), 32'd1);
            checkOutput($sformatf("b2b%0d_d_out", s), 32'(d_out), 32'(model_d(8'h01, 3'(s))));
            checkOutput($sformatf("b2b%0d_c_out", s), 32'(c_out), 32'd0);
            shamt = 3'(s + 1);
        end
        start = 1'b0;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 24; i++) begin
            rd = 8'($urandom);
            rs = 3'($urandom_range(0, 7));
            runAndCheck($sformatf("rand%0d", i), rd, rs, 1'b0, model_d(rd, rs), model_c(rd, rs),
                        model_lat(rs));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
